edge_skew_monitor: RTL

Synchronous, single-clock monitor that measures the cycle-level skew between rising edges on two asynchronous inputs, `sig_a` and `sig_b`, and flags pairs whose skew exceeds a limit. It is the RTL counterpart of the gate-level `$skew` timing check, used where two related strobes or clocks must be checked in silicon rather than only in SDF simulation. It sits downstream of the two signal sources and feeds a status/debug register block.

---
 rtl/edge_skew_pkg.sv | 25 ++
 rtl/edge_sync.sv | 39 +++
 rtl/edge_skew_monitor.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/edge_skew_pkg.sv
`default_nettype none
// ============================================================================
// Package  : edge_skew_pkg
// Purpose  : Shared FSM state encoding and width helpers for edge_skew_monitor.
// Revision : 1.0
// ============================================================================
package edge_skew_pkg;

    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_A = 2'd1,
        ST_WAIT_B = 2'd2
    } state_t;

    // The sign bit sits on top of the unsigned counter range.
    function automatic int skew_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

    localparam int DEF_SKEW_W = skew_w(DEF_CNT_W);

endpackage : edge_skew_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Purpose  : Multi-flop synchronizer followed by a delay flop and rise detector.
// Revision : 1.0
// ============================================================================
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_sig};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign o_rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule : edge_sync
`default_nettype wire

// File: rtl/edge_skew_monitor.sv
`default_nettype none
// ============================================================================
// Module   : edge_skew_monitor
// Purpose  : Measures cycle skew between rising edges of two async inputs and
//            flags pairs beyond MAX_SKEW or with a missing partner edge.
// Revision : 1.0
// ============================================================================
module edge_skew_monitor
    import edge_skew_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MAX_SKEW    = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_a,
    input  logic             sig_b,
    input  logic             clr_cnt,
    output logic             skew_valid,
    output logic [CNT_W:0]   skew_value,
    output logic             skew_viol,
    output logic             timeout,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int               SKEW_W     = skew_w(CNT_W);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [SKEW_W-1:0] MAX_SKEW_C = SKEW_W'(MAX_SKEW);

    logic w_rise_a;
    logic w_rise_b;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (sig_a),
        .o_rise (w_rise_a)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (sig_b),
        .o_rise (w_rise_b)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              skew_valid_q, skew_valid_d;
    logic [SKEW_W-1:0] skew_value_q, skew_value_d;
    logic              skew_viol_q, skew_viol_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  viol_cnt_q, viol_cnt_d;

    logic              w_report;
    logic              w_neg;
    logic [CNT_W-1:0]  w_mag;
    logic              w_timeout;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            skew_valid_q <= 1'b0;
            skew_value_q <= '0;
            skew_viol_q  <= 1'b0;
            timeout_q    <= 1'b0;
            viol_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            skew_valid_q <= skew_valid_d;
            skew_value_q <= skew_value_d;
            skew_viol_q  <= skew_viol_d;
            timeout_q    <= timeout_d;
            viol_cnt_q   <= viol_cnt_d;
        end
    end

    // Next-state: a partner edge always wins over timeout or an orphan edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_report  = 1'b0;
        w_neg     = 1'b0;
        w_mag     = '0;
        w_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_rise_a && w_rise_b) begin
                    w_report = 1'b1;
                end else if (w_rise_a) begin
                    state_d = ST_WAIT_B;
                    cnt_d   = CNT_ONE;
                end else if (w_rise_b) begin
                    state_d = ST_WAIT_A;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT_B: begin
                if (w_rise_b) begin
                    w_report = 1'b1;
                    w_mag    = cnt_q;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == TIMEOUT_C) begin
                    w_timeout = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else if (w_rise_a) begin
                    w_timeout = 1'b1;
                    cnt_d     = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_A: begin
                if (w_rise_a) begin
                    w_report = 1'b1;
                    w_neg    = 1'b1;
                    w_mag    = cnt_q;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == TIMEOUT_C) begin
                    w_timeout = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else if (w_rise_b) begin
                    w_timeout = 1'b1;
                    cnt_d     = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registers; viol_cnt counts the already-registered pulses
    always_comb begin
        skew_valid_d = w_report;
        skew_value_d = skew_value_q;
        skew_viol_d  = 1'b0;
        timeout_d    = w_timeout;
        viol_cnt_d   = viol_cnt_q;
        if (w_report) begin
            skew_value_d = w_neg ? (SKEW_W'(0) - {1'b0, w_mag}) : {1'b0, w_mag};
            skew_viol_d  = ({1'b0, w_mag} > MAX_SKEW_C);
        end
        if (clr_cnt) begin
            viol_cnt_d = '0;
        end else if ((skew_viol_q || timeout_q) && (viol_cnt_q != CNT_MAX)) begin
            viol_cnt_d = viol_cnt_q + CNT_ONE;
        end
    end

    assign skew_valid = skew_valid_q;
    assign skew_value = skew_value_q;
    assign skew_viol  = skew_viol_q;
    assign timeout    = timeout_q;
    assign viol_cnt   = viol_cnt_q;

endmodule : edge_skew_monitor
`default_nettype wire
